// File: rtl/sram_march_bist.sv
// March BIST sequencer for a single-port synchronous SRAM: w(P) up, r(P)w(~P) up,
// r(~P)w(P) down, r(P) down, with a one-cycle read-compare pipeline and sticky status.
module sram_march_bist #(
    parameter int A_WIDTH = 4,
    parameter int D_WIDTH = 8,
    parameter int E_WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [D_WIDTH-1:0] Pattern,
    output logic [A_WIDTH-1:0] Mem_Addr,
    output logic               Mem_En,
    output logic               Mem_RW,
    output logic [D_WIDTH-1:0] Mem_Data_In,
    input  logic [D_WIDTH-1:0] Mem_Data_Out,
    output logic               Busy,
    output logic               Done,
    output logic               Fail,
    output logic [A_WIDTH-1:0] Fail_Addr,
    output logic [D_WIDTH-1:0] Fail_Data,
    output logic [E_WIDTH-1:0] Err_Count
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_M0_W  = 4'd1;
    localparam logic [3:0] S_M1_R  = 4'd2;
    localparam logic [3:0] S_M1_W  = 4'd3;
    localparam logic [3:0] S_M2_R  = 4'd4;
    localparam logic [3:0] S_M2_W  = 4'd5;
    localparam logic [3:0] S_M3_R  = 4'd6;
    localparam logic [3:0] S_DRAIN = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    localparam logic [A_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [A_WIDTH-1:0] ADDR_ONE  = A_WIDTH'(1);
    localparam logic [E_WIDTH-1:0] ERR_MAX   = '1;
    localparam logic [E_WIDTH-1:0] ERR_ONE   = E_WIDTH'(1);

    logic [3:0]         state;
    logic [3:0]         state_nx;
    logic [A_WIDTH-1:0] addr_nx;
    logic [D_WIDTH-1:0] pat;
    logic [D_WIDTH-1:0] pat_nx;
    logic               en_nx;
    logic               rw_nx;
    logic [D_WIDTH-1:0] wdata_nx;
    logic               busy_nx;
    logic               accept;

    logic               read_now;
    logic [D_WIDTH-1:0] read_exp;
    logic               cmp_v;
    logic [A_WIDTH-1:0] cmp_addr;
    logic [D_WIDTH-1:0] cmp_exp;
    logic               mismatch;

    assign accept = (state == S_IDLE) && Start;
    assign pat_nx = accept ? Pattern : pat;

    // Walk the march elements; terminal addresses are compared explicitly, never wrapped.
    always_comb begin
        state_nx = state;
        addr_nx  = Mem_Addr;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nx = S_M0_W;
                    addr_nx  = '0;
                end
            end
            S_M0_W: begin
                if (Mem_Addr == ADDR_LAST) begin
                    state_nx = S_M1_R;
                    addr_nx  = '0;
                end else begin
                    addr_nx = Mem_Addr + ADDR_ONE;
                end
            end
            S_M1_R: state_nx = S_M1_W;
            S_M1_W: begin
                if (Mem_Addr == ADDR_LAST) begin
                    state_nx = S_M2_R;
                    addr_nx  = ADDR_LAST;
                end else begin
                    state_nx = S_M1_R;
                    addr_nx  = Mem_Addr + ADDR_ONE;
                end
            end
            S_M2_R: state_nx = S_M2_W;
            S_M2_W: begin
                if (Mem_Addr == '0) begin
                    state_nx = S_M3_R;
                    addr_nx  = ADDR_LAST;
                end else begin
                    state_nx = S_M2_R;
                    addr_nx  = Mem_Addr - ADDR_ONE;
                end
            end
            S_M3_R: begin
                if (Mem_Addr == '0) begin
                    state_nx = S_DRAIN;
                    addr_nx  = '0;
                end else begin
                    addr_nx = Mem_Addr - ADDR_ONE;
                end
            end
            S_DRAIN: begin
                state_nx = S_DONE;
                addr_nx  = '0;
            end
            S_DONE: begin
                state_nx = S_IDLE;
                addr_nx  = '0;
            end
            default: begin
                state_nx = S_IDLE;
                addr_nx  = '0;
            end
        endcase
    end

    // SRAM controls are decoded from the next state so the Mem_* pins are registered.
    always_comb begin
        en_nx    = 1'b0;
        rw_nx    = 1'b0;
        wdata_nx = '0;
        case (state_nx)
            S_M0_W: begin
                en_nx    = 1'b1;
                rw_nx    = 1'b1;
                wdata_nx = pat_nx;
            end
            S_M1_W: begin
                en_nx    = 1'b1;
                rw_nx    = 1'b1;
                wdata_nx = ~pat_nx;
            end
            S_M2_W: begin
                en_nx    = 1'b1;
                rw_nx    = 1'b1;
                wdata_nx = pat_nx;
            end
            S_M1_R, S_M2_R, S_M3_R: en_nx = 1'b1;
            default: en_nx = 1'b0;
        endcase
    end

    assign busy_nx  = (state_nx != S_IDLE) && (state_nx != S_DONE);
    assign read_now = Mem_En && !Mem_RW;
    assign read_exp = (state == S_M2_R) ? ~pat : pat;
    assign mismatch = cmp_v && (Mem_Data_Out != cmp_exp);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= S_IDLE;
            pat         <= '0;
            Mem_Addr    <= '0;
            Mem_En      <= 1'b0;
            Mem_RW      <= 1'b0;
            Mem_Data_In <= '0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            pat         <= pat_nx;
            Mem_Addr    <= addr_nx;
            Mem_En      <= en_nx;
            Mem_RW      <= rw_nx;
            Mem_Data_In <= wdata_nx;
            Busy        <= busy_nx;
        end
    end

    // Read data returns one cycle after issue, so the expectation travels one stage.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cmp_v    <= 1'b0;
            cmp_addr <= '0;
            cmp_exp  <= '0;
        end else begin
            cmp_v    <= read_now;
            cmp_addr <= Mem_Addr;
            cmp_exp  <= read_exp;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Done      <= 1'b0;
            Fail      <= 1'b0;
            Fail_Addr <= '0;
            Fail_Data <= '0;
            Err_Count <= '0;
        end else if (accept) begin
            Done      <= 1'b0;
            Fail      <= 1'b0;
            Fail_Addr <= '0;
            Fail_Data <= '0;
            Err_Count <= '0;
        end else begin
            if (state_nx == S_DONE) begin
                Done <= 1'b1;
            end
            if (mismatch) begin
                if (Err_Count != ERR_MAX) begin
                    Err_Count <= Err_Count + ERR_ONE;
                end
                if (!Fail) begin
                    Fail      <= 1'b1;
                    Fail_Addr <= cmp_addr;
                    Fail_Data <= Mem_Data_Out;
                end
            end
        end
    end

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
Built-in self-test sequencer directly upstream of the single-port synchronous SRAM. It owns the SRAM address, enable, read/write and write-data inputs. It runs a four-element march test over every address and checks the SRAM's registered read data. It reports pass/fail, the first failing address and data, and a saturating error count to the system controller.

Parameters:
A_WIDTH, 4, SRAM address width; test covers N = 2**A_WIDTH words
D_WIDTH, 8, SRAM data width
E_WIDTH, 8, error counter width

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous active-low reset
Start  input  1  1-cycle pulse, begins a test when idle
Pattern  input  D_WIDTH  background pattern P, sampled on accepted Start
Mem_Addr  output  A_WIDTH  to SRAM Addr
Mem_En  output  1  to SRAM En
Mem_RW  output  1  to SRAM RW; 1 = write, 0 = read
Mem_Data_In  output  D_WIDTH  to SRAM Data_In
Mem_Data_Out  input  D_WIDTH  from SRAM Data_Out; valid 1 cycle after read issue, zero otherwise
Busy  output  1  test in progress
Done  output  1  test complete, sticky until next accepted Start
Fail  output  1  at least one mismatch, sticky until next accepted Start
Fail_Addr  output  A_WIDTH  address of first mismatch
Fail_Data  output  D_WIDTH  read data of first mismatch
Err_Count  output  E_WIDTH  total mismatches, saturates at all-ones

Behaviour:
- Reset (Rst=0, async): state IDLE. All outputs 0. Latched pattern 0. Compare pipeline cleared. This block never drives the SRAM's own reset.
- IDLE: Mem_En=0. Start=1 latches Pattern into P, clears Done/Fail/Fail_Addr/Fail_Data/Err_Count, sets Busy, and moves to M0_W with address 0. Start while Busy=1 is ignored.
- M0_W (ascending): write P at addr 0..N-1, one write per cycle. After N-1, go to M1_R with addr 0.
- M1_R/M1_W (ascending), per address: read (expect P), then write ~P at the same address on the next cycle. After M1_W at N-1, go to M2_R with addr N-1.
- M2_R/M2_W (descending), per address: read (expect ~P), then write P. After M2_W at addr 0, go to M3_R with addr N-1.
- M3_R (descending): read (expect P) every cycle. After addr 0, go to DRAIN.
- DRAIN: Mem_En=0; performs the final compare, then goes to DONE.
- DONE: Busy=0, Done=1, Mem_En=0; next state IDLE (Done stays 1).
- Total: 6N+1 cycles from first M0_W cycle to DONE; N=16 gives 97.
- Compare pipeline:
  - Each cycle a read is issued, register cmp_v=1, cmp_addr=Mem_Addr and cmp_exp=expected value.
  - On the following cycle, if cmp_v and Mem_Data_Out != cmp_exp, it is a mismatch.
  - On a mismatch, Err_Count increments, saturating at 2**E_WIDTH-1.
  - On the first mismatch only: Fail=1, Fail_Addr=cmp_addr, Fail_Data=Mem_Data_Out.
  - A compare may coincide with the next read or write issue; both proceed in the same cycle.
- Outputs Mem_* are registered. Address wrap is never used; terminal addresses are detected explicitly (0 and N-1).
- Mem_Data_In = 0 whenever Mem_RW=0 or Mem_En=0.
- Rst asserted mid-test: immediate return to IDLE, all outputs 0, no Done.

Test Plan:
- Reset then Start with Pattern=8'hA5 against a fault-free SRAM -> Busy for 97 cycles; Done=1, Fail=0, Err_Count=0; write/read sequence on Mem_* matches the march order exactly.
- SRAM model with addr 5 bit0 stuck-at-1, Pattern=8'h00 -> Fail=1, Fail_Addr=5, Fail_Data=8'h01 (from M1), Err_Count=2 (M1 and M3 reads).
- Start pulsed again at cycle 40 of a running test -> ignored; completes at cycle 97 with the original pattern.
- Rst driven low at cycle 50 -> all outputs 0 within the same cycle; fresh Start gives a clean 97-cycle pass.
- All words forced to mismatch with E_WIDTH=4 -> Err_Count saturates at 4'hF; Fail_Addr=0 (first M1 read).
- Second test after a failing one, with a fault-free SRAM -> Fail/Err_Count cleared on Start; Done=1, Fail=0.
